// File: rtl/tff_bank_counter.sv
// rtl/tff_bank_counter.sv - WIDTH-bit toggle/up/down/hold counter with load, terminal count and sticky wrap flag
module tff_bank_counter #(
  parameter int     WIDTH     = 8,
  parameter longint MODULUS   = 256,
  parameter longint RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_wrap,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap_flag
);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  // Highest legal count; with MODULUS = 2^WIDTH this is all-ones, giving natural binary wrap.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_next;
  logic             tc_next;

  // Complement follows q combinationally, including while reset is held.
  assign qbar = ~q;

  // Next-state selection: load beats enable, enable lets the mode pick the update.
  always_comb begin
    q_next  = q;
    tc_next = 1'b0;
    if (load) begin
      q_next = din;
    end else if (en) begin
      case (mode)
        MODE_TOGGLE: begin
          q_next = q ^ t;
        end
        MODE_UP: begin
          // Anything at or beyond the top (including out-of-range loads) wraps to zero.
          if (q >= MAX_VAL) begin
            q_next  = '0;
            tc_next = 1'b1;
          end else begin
            q_next = q + 1'b1;
          end
        end
        MODE_DOWN: begin
          // Only a real underflow from zero is a wrap; an out-of-range value just clamps.
          if (q == '0) begin
            q_next  = MAX_VAL;
            tc_next = 1'b1;
          end else if (q > MAX_VAL) begin
            q_next = MAX_VAL;
          end else begin
            q_next = q - 1'b1;
          end
        end
        default: begin
          q_next = q;
        end
      endcase
    end
  end

  // State register; a wrap on the same edge as clr_wrap keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q         <= RST_Q;
      tc        <= 1'b0;
      wrap_flag <= 1'b0;
    end else begin
      q  <= q_next;
      tc <= tc_next;
      if (tc_next) begin
        wrap_flag <= 1'b1;
      end else if (clr_wrap) begin
        wrap_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tff_bank_counter.sv
// tb/tb_tff_bank_counter.sv - self-checking bench for tff_bank_counter against a behavioural model
module tb_tff_bank_counter;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] t;
  logic       load;
  logic [7:0] din;
  logic       clr_wrap;

  logic [7:0] q_o  [N];
  logic [7:0] qb_o [N];
  logic       tc_o [N];
  logic       wf_o [N];

  int m_mod [N];
  int m_rv  [N];
  int mq    [N];
  int mtc   [N];
  int mwf   [N];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  tff_bank_counter #(.WIDTH(8), .MODULUS(10), .RESET_VAL(5)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load(load), .din(din),
    .clr_wrap(clr_wrap), .q(q_o[0]), .qbar(qb_o[0]), .tc(tc_o[0]), .wrap_flag(wf_o[0]));

  tff_bank_counter #(.WIDTH(8), .MODULUS(2), .RESET_VAL(0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load(load), .din(din),
    .clr_wrap(clr_wrap), .q(q_o[1]), .qbar(qb_o[1]), .tc(tc_o[1]), .wrap_flag(wf_o[1]));

  tff_bank_counter #(.WIDTH(8), .MODULUS(256), .RESET_VAL(0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load(load), .din(din),
    .clr_wrap(clr_wrap), .q(q_o[2]), .qbar(qb_o[2]), .tc(tc_o[2]), .wrap_flag(wf_o[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all(input string ctx);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s.q%0d", ctx, i),    32'(q_o[i]),  mq[i]);
      chk($sformatf("%s.qbar%0d", ctx, i), 32'(qb_o[i]), (~mq[i]) & 255);
      chk($sformatf("%s.tc%0d", ctx, i),   32'(tc_o[i]), mtc[i]);
      chk($sformatf("%s.wf%0d", ctx, i),   32'(wf_o[i]), mwf[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i]  = m_rv[i];
      mtc[i] = 0;
      mwf[i] = 0;
    end
  endtask

  task automatic set_in(input logic l, input int d, input logic e, input int m,
                        input int tt, input logic c);
    load     = l;
    din      = 8'(d);
    en       = e;
    mode     = 2'(m);
    t        = 8'(tt);
    clr_wrap = c;
  endtask

  // One clock: predict from the rules, clock the DUTs, compare just after the edge.
  task automatic tick(input string ctx);
    int nq  [N];
    int ntc [N];
    for (int i = 0; i < N; i++) begin
      nq[i]  = mq[i];
      ntc[i] = 0;
      if (load) begin
        nq[i] = int'(din);
      end else if (en) begin
        if (mode == 2'd0) begin
          nq[i] = mq[i] ^ int'(t);
        end else if (mode == 2'd1) begin
          if (mq[i] + 1 >= m_mod[i]) begin
            nq[i]  = 0;
            ntc[i] = 1;
          end else begin
            nq[i] = mq[i] + 1;
          end
        end else if (mode == 2'd2) begin
          if (mq[i] == 0) begin
            nq[i]  = m_mod[i] - 1;
            ntc[i] = 1;
          end else if (mq[i] >= m_mod[i]) begin
            nq[i] = m_mod[i] - 1;
          end else begin
            nq[i] = mq[i] - 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      mq[i]  = nq[i];
      mtc[i] = ntc[i];
      if (ntc[i] != 0) mwf[i] = 1;
      else if (clr_wrap) mwf[i] = 0;
    end
    check_all(ctx);
  endtask

  // Assert reset between edges, check before the next edge, hold over one edge, release.
  task automatic async_reset(input string ctx);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all({ctx, ".mid"});
    @(posedge clk);
    #1;
    check_all({ctx, ".held"});
    rst = 1'b1;
  endtask

  initial begin
    m_mod[0] = 10;  m_rv[0] = 5;
    m_mod[1] = 2;   m_rv[1] = 0;
    m_mod[2] = 256; m_rv[2] = 0;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.q_const", 32'(q_o[0]), 5);
    chk("reset.qbar_const", 32'(qb_o[0]), 8'hFA);
    rst = 1'b1;

    // TOGGLE from zero with mask A5.
    set_in(1, 0, 0, 0, 0, 0); tick("ld0");
    set_in(0, 0, 1, 0, 8'hA5, 0);
    tick("tog1");
    chk("tog1.q", 32'(q_o[0]), 8'hA5);
    chk("tog1.qbar", 32'(qb_o[0]), 8'h5A);
    tick("tog2");
    chk("tog2.q", 32'(q_o[0]), 8'h00);
    chk("tog2.qbar", 32'(qb_o[0]), 8'hFF);
    chk("tog2.tc", 32'(tc_o[0]), 0);

    // UP wrap at MODULUS=10 from 7.
    set_in(1, 7, 0, 0, 0, 0); tick("ld7");
    set_in(0, 0, 1, 1, 0, 0);
    tick("up1"); chk("up1.q", 32'(q_o[0]), 8); chk("up1.tc", 32'(tc_o[0]), 0);
    tick("up2"); chk("up2.q", 32'(q_o[0]), 9); chk("up2.tc", 32'(tc_o[0]), 0);
    tick("up3"); chk("up3.q", 32'(q_o[0]), 0); chk("up3.tc", 32'(tc_o[0]), 1);
    tick("up4"); chk("up4.q", 32'(q_o[0]), 1); chk("up4.tc", 32'(tc_o[0]), 0);
    chk("up4.wf", 32'(wf_o[0]), 1);

    // DOWN wrap and out-of-range clamp.
    set_in(1, 1, 0, 0, 0, 0); tick("ld1");
    set_in(0, 0, 1, 2, 0, 0);
    tick("dn1"); chk("dn1.q", 32'(q_o[0]), 0); chk("dn1.tc", 32'(tc_o[0]), 0);
    tick("dn2"); chk("dn2.q", 32'(q_o[0]), 9); chk("dn2.tc", 32'(tc_o[0]), 1);
    set_in(1, 200, 0, 0, 0, 0); tick("ld200");
    chk("ld200.q", 32'(q_o[0]), 200);
    set_in(0, 0, 1, 2, 0, 0);
    tick("dn3"); chk("dn3.q", 32'(q_o[0]), 9); chk("dn3.tc", 32'(tc_o[0]), 0);

    // Load outranks enable, then enable low holds.
    set_in(1, 3, 1, 1, 0, 0);
    tick("prio"); chk("prio.q", 32'(q_o[0]), 3); chk("prio.tc", 32'(tc_o[0]), 0);
    set_in(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick("hold");
      chk($sformatf("hold%0d.q", k), 32'(q_o[0]), 3);
    end

    // Natural binary wrap at MODULUS=256.
    set_in(1, 255, 0, 0, 0, 0); tick("ld255");
    set_in(0, 0, 1, 1, 0, 0);
    tick("nat"); chk("nat.q", 32'(q_o[2]), 0); chk("nat.tc", 32'(tc_o[2]), 1);

    // Set/clear race on the MODULUS=2 instance.
    set_in(1, 0, 0, 0, 0, 0); tick("ld0b");
    set_in(0, 0, 1, 1, 0, 1);
    for (int k = 0; k < 6; k++) begin
      tick("race");
      if (tc_o[1]) chk($sformatf("race%0d.wf", k), 32'(wf_o[1]), 1);
    end
    set_in(0, 0, 0, 1, 0, 1);
    tick("clr"); chk("clr.wf", 32'(wf_o[1]), 0);

    // Mid-operation async reset.
    set_in(0, 0, 1, 1, 0, 0);
    tick("pre_rst");
    async_reset("rst1");

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_reset("rnd_rst");
      end else begin
        set_in($urandom_range(0, 7) == 0, int'($urandom_range(0, 255)),
               $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
               int'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
        tick("rnd");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
